// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encoding,
// opcode and funct values, ALU operation classes and alucontrol codes.
// Optional feature macro: MIPS_CTRL_ADDI_EN (adds the ADDI execute/writeback states).
package mips_pkg;

    // State encoding (4 bits, value 15 is unused and treated as illegal)
    typedef logic [3:0] state_t;
    localparam state_t FETCH1  = 4'd0;
    localparam state_t FETCH2  = 4'd1;
    localparam state_t FETCH3  = 4'd2;
    localparam state_t FETCH4  = 4'd3;
    localparam state_t DECODE  = 4'd4;
    localparam state_t MEMADR  = 4'd5;
    localparam state_t LBRD    = 4'd6;
    localparam state_t LBWR    = 4'd7;
    localparam state_t SBWR    = 4'd8;
    localparam state_t RTYPEEX = 4'd9;
    localparam state_t RTYPEWR = 4'd10;
    localparam state_t BEQEX   = 4'd11;
    localparam state_t JEX     = 4'd12;
    localparam state_t ADDIEX  = 4'd13;
    localparam state_t ADDIWR  = 4'd14;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation class requested by the FSM; NONE drives alucontrol to 000
    typedef logic [1:0] aluop_t;
    localparam aluop_t ALUOP_NONE  = 2'b00;
    localparam aluop_t ALUOP_ADD   = 2'b01;
    localparam aluop_t ALUOP_SUB   = 2'b10;
    localparam aluop_t ALUOP_FUNCT = 2'b11;

    // alucontrol codes
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;
    localparam logic [2:0] ALU_NONE = 3'b000;

endpackage

// File: rtl/mips_aludec.sv
// ALU decoder: maps the FSM's ALU operation class and the R-type funct
// field onto the 3-bit alucontrol code.
module mips_aludec
    import mips_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    // Fixed add/sub for address and branch math, funct lookup for R-type
    always_comb begin
        alucontrol = ALU_NONE;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_NONE;
        endcase
    end

endmodule

// File: rtl/mips_controller.sv
// Multicycle MIPS controller: Moore FSM fetching a 32-bit instruction one
// byte per cycle, then sequencing LB, SB, R-type, BEQ, J (and optionally ADDI).
// Optional feature macro: MIPS_CTRL_ADDI_EN (ADDIEX/ADDIWR states, op 001000).
// While reset is low every output, including alucontrol, is held at 0.
// state_dbg exposes the current state encoding for observation.
module mips_controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memread,
    output logic       memwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic [3:0] irwrite,
    output logic [1:0] pcsource,
    output logic       pcen,
    output logic [2:0] alucontrol,
    output logic [3:0] state_dbg
);

    state_t     state;
    state_t     next_state;
    aluop_t     aluop;
    logic [2:0] alu_raw;
    logic       pcwrite;
    logic       branch;
    logic       c_memread, c_memwrite, c_alusrca, c_iord;
    logic       c_memtoreg, c_regdst, c_regwrite;
    logic [1:0] c_alusrcb, c_pcsource;
    logic [3:0] c_irwrite;

    // State register; reset drops straight to FETCH1 without waiting for clk
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH1;
        else        state <= next_state;
    end

    // Next-state logic; illegal encodings fall back to FETCH1
    always_comb begin
        next_state = FETCH1;
        case (state)
            FETCH1: next_state = FETCH2;
            FETCH2: next_state = FETCH3;
            FETCH3: next_state = FETCH4;
            FETCH4: next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_LB, OP_SB: next_state = MEMADR;
                    OP_RTYPE:     next_state = RTYPEEX;
                    OP_BEQ:       next_state = BEQEX;
                    OP_J:         next_state = JEX;
`ifdef MIPS_CTRL_ADDI_EN
                    OP_ADDI:      next_state = ADDIEX;
`endif
                    default:      next_state = FETCH1;
                endcase
            end
            MEMADR: begin
                if (op == OP_SB)      next_state = SBWR;
                else if (op == OP_LB) next_state = LBRD;
                else                  next_state = FETCH1;
            end
            LBRD:    next_state = LBWR;
            LBWR:    next_state = FETCH1;
            SBWR:    next_state = FETCH1;
            RTYPEEX: next_state = RTYPEWR;
            RTYPEWR: next_state = FETCH1;
            BEQEX:   next_state = FETCH1;
            JEX:     next_state = FETCH1;
`ifdef MIPS_CTRL_ADDI_EN
            ADDIEX:  next_state = ADDIWR;
            ADDIWR:  next_state = FETCH1;
`endif
            default: next_state = FETCH1;
        endcase
    end

    // Moore output decode; anything not set for a state stays 0
    always_comb begin
        c_memread  = 1'b0;
        c_memwrite = 1'b0;
        c_alusrca  = 1'b0;
        c_alusrcb  = 2'b00;
        c_iord     = 1'b0;
        c_memtoreg = 1'b0;
        c_regdst   = 1'b0;
        c_regwrite = 1'b0;
        c_irwrite  = 4'b0000;
        c_pcsource = 2'b00;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        aluop      = ALUOP_NONE;
        case (state)
            FETCH1, FETCH2, FETCH3, FETCH4: begin
                c_memread = 1'b1;
                c_irwrite = 4'b0001 << state[1:0];
                c_alusrcb = 2'b01;
                aluop     = ALUOP_ADD;
                pcwrite   = 1'b1;
            end
            DECODE: begin
                c_alusrcb = 2'b11;
                aluop     = ALUOP_ADD;
            end
            MEMADR: begin
                c_alusrca = 1'b1;
                c_alusrcb = 2'b10;
                aluop     = ALUOP_ADD;
            end
            LBRD: begin
                c_memread = 1'b1;
                c_iord    = 1'b1;
            end
            LBWR: begin
                c_regwrite = 1'b1;
                c_memtoreg = 1'b1;
            end
            SBWR: begin
                c_memwrite = 1'b1;
                c_iord     = 1'b1;
            end
            RTYPEEX: begin
                c_alusrca = 1'b1;
                aluop     = ALUOP_FUNCT;
            end
            RTYPEWR: begin
                c_regwrite = 1'b1;
                c_regdst   = 1'b1;
            end
            BEQEX: begin
                c_alusrca  = 1'b1;
                aluop      = ALUOP_SUB;
                branch     = 1'b1;
                c_pcsource = 2'b01;
            end
            JEX: begin
                pcwrite    = 1'b1;
                c_pcsource = 2'b10;
            end
`ifdef MIPS_CTRL_ADDI_EN
            ADDIEX: begin
                c_alusrca = 1'b1;
                c_alusrcb = 2'b10;
                aluop     = ALUOP_ADD;
            end
            ADDIWR: begin
                c_regwrite = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    mips_aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alu_raw)
    );

    // Outputs are forced low for as long as reset is held
    assign memread    = reset & c_memread;
    assign memwrite   = reset & c_memwrite;
    assign alusrca    = reset & c_alusrca;
    assign alusrcb    = reset ? c_alusrcb  : 2'b00;
    assign iord       = reset & c_iord;
    assign memtoreg   = reset & c_memtoreg;
    assign regdst     = reset & c_regdst;
    assign regwrite   = reset & c_regwrite;
    assign irwrite    = reset ? c_irwrite  : 4'b0000;
    assign pcsource   = reset ? c_pcsource : 2'b00;
    assign pcen       = reset & (pcwrite | (branch & zero));
    assign alucontrol = reset ? alu_raw    : 3'b000;
    assign state_dbg  = state;

endmodule
